instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface. Drives the word address into the combinational-read memory and captures the returned word.
- Buffers fetched instructions with their PC in a small prefetch queue.
- Presents them to the decode stage over a valid/ready handshake.
- Sits between the PC/branch logic and the first pipeline stage of the four-stage pipeline.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, word address loaded into the PC on reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (block is in reset while rst=0).
- fetch_en  input  1  allows new memory reads when 1.
- redirect  input  1  branch/jump: flush the queue and load redirect_pc.
- redirect_pc  input  `ASIZE  new fetch word address.
- imem_addr  output  `ASIZE  word address to instruction memory; equals pc_q.
- imem_wen  output  1  constant 0; the fetch side never writes.
- imem_data  input  `DSIZE  instruction word returned combinationally for imem_addr in the same cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  `DSIZE  head instruction.
- out_pc  output  `ASIZE  word address of the head instruction.
- q_count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC, queue empty, q_count=0, out_valid=0.
  - out_instr=0 and out_pc=0 (outputs forced to 0 when empty).
  - imem_addr=RESET_PC.
- Definitions:
  - pop = out_valid & out_ready.
  - push = fetch_en & ~redirect & (q_count<DEPTH | pop).
- Push: write {pc_q, imem_data} at the tail; pc_q <= pc_q+1, modulo 2^`ASIZE, so the maximum address wraps to 0.
- Pop: advance the head.
- Simultaneous push and pop:
  - Legal when full; occupancy stays unchanged.
  - When empty, a push and a pop in the same cycle is impossible, because out_valid=0.
- Queue is first-word-fall-through:
  - out_valid = (q_count!=0); out_instr/out_pc are taken from the head entry combinationally.
  - When empty, out_instr=0 and out_pc=0.
- Latency: the word at address A is captured at the clock edge that ends the cycle in which imem_addr=A. It appears on out_* the following cycle, one cycle from address to output.
- Throughput: one instruction per cycle while decode keeps up.
- Redirect has the highest priority:
  - At the clock edge, the queue is flushed (q_count=0) and pc_q <= redirect_pc.
  - No push that cycle.
  - A concurrent pop is discarded with the flush; decode must treat the accepted word as killed.
  - out_valid=0 the cycle after redirect; the first instruction from redirect_pc is valid the cycle after that.
- fetch_en=0: no push, pc_q holds, and pops continue draining the queue.
- Full and no pop: no push; pc_q holds, so the same address is re-presented without skipping.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending entries are lost.
- imem_data is sampled only when push=1; X on imem_data at any other time must not propagate.
- Pointers are $clog2(DEPTH)-bit and wrap naturally. q_count is tracked separately, so full and empty are unambiguous.

Decomposition:
- define.v (shared):
  - reuse `ASIZE and `DSIZE.
  - add `FETCH_DEPTH (default 4) and `RESET_PC (default 0) so the top level and the bench agree.
- One sub-module, fetch_fifo:
  - parameterised synchronous FWFT FIFO with width `ASIZE+`DSIZE and DEPTH entries.
  - ports: push/pop, flush, data in/out, count.
  - active-low asynchronous reset.
- instr_fetch_unit holds pc_q, the push/pop/redirect logic, and the memory-side ports.

Test Plan:
- Reset then streaming: rst low 2 cycles, then high; fetch_en=1, out_ready=1; memory preloaded word[n]=n+0x100.
  - Required: out_valid rises on the 2nd cycle after reset release.
  - out_pc=0,1,2,... with out_instr=0x100,0x101,... on consecutive cycles.
- Backpressure fill: out_ready=0 for 8 cycles.
  - Required: q_count reaches 4 and stays; imem_addr holds at 4.
  - On out_ready=1: pcs 0..7 delivered in order, no gaps or duplicates.
- Full with simultaneous push/pop: queue full, out_ready=1 for 3 cycles.
  - Required: q_count stays 4; out_pc advances by 1 per cycle; imem_addr advances by 1 per cycle.
- Redirect while full: queue holds pcs 0-3, pulse redirect with redirect_pc=0x20 for one cycle.
  - Required: the next cycle shows q_count=0 and out_valid=0.
  - The cycle after that shows out_pc=0x20, out_instr=word[0x20].
- Address wrap: redirect_pc = 2^`ASIZE-2.
  - Required: out_pc sequence is 2^`ASIZE-2, 2^`ASIZE-1, 0, 1.
- Async reset mid-stream: drop rst between clock edges with 3 entries queued.
  - Required: out_valid=0, q_count=0, imem_addr=RESET_PC immediately, without waiting for a clock edge.
  - imem_wen is 0 throughout the test.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its bench.
// ASIZE / DSIZE   : instruction-memory word address and data widths.
// FETCH_DEPTH     : default prefetch queue depth.
// RESET_PC_DEF    : default word address loaded into the PC on reset.
// fetch_entry_t   : one prefetch queue entry, {pc, instr}.
package instr_fetch_unit_pkg;
  localparam int ASIZE       = 8;
  localparam int DSIZE       = 32;
  localparam int FETCH_DEPTH = 4;
  localparam logic [ASIZE-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [ASIZE-1:0] pc;
    logic [DSIZE-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// First-word-fall-through FIFO used as the fetch prefetch queue.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   push  : write din at the tail
//   pop   : advance the head (only when count != 0)
//   flush : empty the queue; overrides push and pop
//   din   : entry to write
//   dout  : head entry, forced to 0 when empty
//   count : number of occupied entries
module fetch_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally; occupancy is kept separately so full/empty never alias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is written only on a real push, so undefined input data never lands in the queue.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory word address, captures
// the combinationally returned word into a prefetch queue together with its PC,
// and hands entries to decode over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   fetch_en          : allow new memory reads
//   redirect          : flush the queue and load redirect_pc (highest priority)
//   redirect_pc       : new fetch word address
//   imem_addr         : word address to memory (current PC)
//   imem_wen          : always 0
//   imem_data         : word returned for imem_addr in the same cycle
//   out_valid/ready   : decode handshake
//   out_instr/out_pc  : head entry, 0 when empty
//   q_count           : queue occupancy
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int               DEPTH    = FETCH_DEPTH,
  parameter logic [ASIZE-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [ASIZE-1:0]       redirect_pc,
  output logic [ASIZE-1:0]       imem_addr,
  output logic                   imem_wen,
  input  logic [DSIZE-1:0]       imem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DSIZE-1:0]       out_instr,
  output logic [ASIZE-1:0]       out_pc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ASIZE-1:0] r_pc;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [CW-1:0]    w_count;
  fetch_entry_t     w_din;
  fetch_entry_t     w_dout;

  assign w_full = (w_count == CW'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign w_push = fetch_en & ~redirect & (~w_full | w_pop);

  assign w_din.pc    = r_pc;
  assign w_din.instr = imem_data;

  // A pop coinciding with redirect is swallowed by the flush.
  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );

  // PC advances only when its word was captured, so a stall re-presents the same address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ASIZE'(1);
    end
  end

  assign imem_addr = r_pc;
  assign imem_wen  = 1'b0;
  assign out_valid = (w_count != '0);
  assign out_instr = w_dout.instr;
  assign out_pc    = w_dout.pc;
  assign q_count   = w_count;
endmodule
